t_latch: RTL and testbench

Clock-synchronous model of a level-enabled toggle (T) latch bank. While `enable` is high, each bit whose `t` input is high inverts its stored state. While `enable` is low, the state holds. It sits in the sequential-primitives library as a reusable toggle storage element and drives complementary outputs `q` / `q_bar`.

---
 rtl/t_latch.sv | 99 +++++++++
 tb/tb_t_latch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/t_latch.sv
// t_latch: bank of WIDTH clock-synchronous toggle cells sharing one enable.
// While enable is high each bit with t high inverts on every rising clk edge;
// q_bar is the combinational complement of the q register and toggled pulses
// for one cycle after a bit of q changes.
// Reset is asynchronous on assertion; its release passes through a two-flop
// synchronizer so the first toggle can happen at the 2nd edge after release.
// Optional build macro T_LATCH_ONESHOT_EN: each bit toggles at most once per
// enable window and re-arms when t[i] or enable is sampled low.
module t_latch #(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    input  logic             enable,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] toggled
);

    // Valid/ready handshake does not apply: t and enable are level inputs
    // sampled at every rising edge, and outputs are always valid.

    logic [1:0]       rel_q;
    logic             released;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] toggled_q;
    logic [WIDTH-1:0] toggled_d;
    logic [WIDTH-1:0] fire;
`ifdef T_LATCH_ONESHOT_EN
    logic [WIDTH-1:0] armed_q;
    logic [WIDTH-1:0] armed_d;
`endif

    // Release synchronizer: both stages clear asynchronously on rst and fill
    // with ones after release; the cells open once the first stage has
    // captured the release edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rel_q <= 2'b00;
        end else begin
            rel_q <= {rel_q[0], 1'b1};
        end
    end

    assign released = |rel_q;

    // Per-bit next state; X on t or enable fails the == 1'b1 test and holds.
    always_comb begin
        fire = '0;
`ifdef T_LATCH_ONESHOT_EN
        armed_d = armed_q;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            if (released) begin
                if (enable == 1'b1 && t[i] == 1'b1) begin
`ifdef T_LATCH_ONESHOT_EN
                    fire[i]    = armed_q[i];
                    armed_d[i] = 1'b0;
`else
                    fire[i]    = 1'b1;
`endif
                end else begin
`ifdef T_LATCH_ONESHOT_EN
                    armed_d[i] = 1'b1;
`else
                    fire[i]    = 1'b0;
`endif
                end
            end
        end
        q_d       = q_q ^ fire;
        toggled_d = fire;
    end

    // State registers: q, the one-cycle toggle pulse and (oneshot) arm flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q       <= INIT;
            toggled_q <= '0;
`ifdef T_LATCH_ONESHOT_EN
            armed_q   <= '1;
`endif
        end else begin
            q_q       <= q_d;
            toggled_q <= toggled_d;
`ifdef T_LATCH_ONESHOT_EN
            armed_q   <= armed_d;
`endif
        end
    end

    assign q       = q_q;
    assign q_bar   = ~q_q;
    assign toggled = toggled_q;

endmodule

// File: tb/tb_t_latch.sv
// tb_t_latch: directed and randomized checks for t_latch, one WIDTH=1
// instance (INIT=0) and one WIDTH=4 instance (INIT=4'b0101).
module tb_t_latch;

    logic       clk;
    logic       rst;
    logic       t1;
    logic       en1;
    logic [3:0] t4;
    logic       en4;
    logic       q1;
    logic       qb1;
    logic       tg1;
    logic [3:0] q4;
    logic [3:0] qb4;
    logic [3:0] tg4;

    int checks   = 0;
    int failures = 0;

    // Expected entry: {sel4, q[3:0], toggled[3:0]}.
    logic [8:0] exp_q[$];

    t_latch #(.WIDTH(1), .INIT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .t(t1), .enable(en1),
        .q(q1), .q_bar(qb1), .toggled(tg1)
    );

    t_latch #(.WIDTH(4), .INIT(4'b0101)) dut4 (
        .clk(clk), .rst(rst), .t(t4), .enable(en4),
        .q(q4), .q_bar(qb4), .toggled(tg4)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: after each rising edge, compare whatever the drivers queued.
    always @(posedge clk) begin
        logic [8:0] e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[8]) begin
                chk("q4", q4, e[7:4]);
                chk("q_bar4", qb4, ~e[7:4]);
                chk("toggled4", tg4, e[3:0]);
            end else begin
                chk("q1", {3'b000, q1}, {3'b000, e[4]});
                chk("q_bar1", {3'b000, qb1}, {3'b000, ~e[4]});
                chk("toggled1", {3'b000, tg1}, {3'b000, e[0]});
            end
        end
    end

    task automatic cyc1(input logic t, input logic en, input logic eq, input logic etg);
        @(negedge clk);
        t1  = t;
        en1 = en;
        exp_q.push_back({1'b0, 3'b000, eq, 3'b000, etg});
        @(posedge clk);
    endtask

    task automatic cyc4(input logic [3:0] t, input logic en, input logic [3:0] eq,
                        input logic [3:0] etg);
        @(negedge clk);
        t4  = t;
        en4 = en;
        exp_q.push_back({1'b1, eq, etg});
        @(posedge clk);
    endtask

    task automatic random_phase();
        logic mq;
        logic mtg;
        logic marmed;
        int   rel;
        logic r;
        logic tt;
        logic ee;
        logic fire;
        // Start from a known reset.
        @(negedge clk);
        rst = 1'b1;
        t1  = 1'b0;
        en1 = 1'b0;
        mq = 1'b0; mtg = 1'b0; marmed = 1'b1; rel = 0;
        exp_q.push_back({1'b0, 4'b0000, 4'b0000});
        @(posedge clk);
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            r  = ($urandom_range(0, 19) == 0);
            tt = 1'($urandom_range(0, 1));
            ee = ($urandom_range(0, 3) != 0);
            rst = r;
            t1  = tt;
            en1 = ee;
            if (r) begin
                mq = 1'b0; mtg = 1'b0; marmed = 1'b1; rel = 0;
            end else begin
                fire = 1'b0;
                if (rel >= 1) begin
                    if (ee && tt) begin
`ifdef T_LATCH_ONESHOT_EN
                        fire   = marmed;
`else
                        fire   = 1'b1;
`endif
                        marmed = 1'b0;
                    end else begin
                        marmed = 1'b1;
                    end
                end
                mq  = mq ^ fire;
                mtg = fire;
                if (rel < 2) rel++;
            end
            exp_q.push_back({1'b0, 3'b000, mq, 3'b000, mtg});
            @(posedge clk);
        end
    endtask

    // Stimulus
    initial begin
        rst = 1'b1;
        t1  = 1'b0;
        en1 = 1'b0;
        t4  = 4'b0000;
        en4 = 1'b0;

        // Reset values without any clock edge.
        #2;
        chk("reset_q1", {3'b000, q1}, 4'b0000);
        chk("reset_q_bar1", {3'b000, qb1}, 4'b0001);
        chk("reset_toggled1", {3'b000, tg1}, 4'b0000);
        chk("reset_q4", q4, 4'b0101);
        chk("reset_q_bar4", qb4, 4'b1010);
        chk("reset_toggled4", tg4, 4'b0000);

        @(negedge clk);
        rst = 1'b0;

        // Hold: enable low with t high.
        for (int i = 0; i < 5; i++) cyc1(1'b1, 1'b0, 1'b0, 1'b0);

        // Toggle sequence.
`ifdef T_LATCH_ONESHOT_EN
        cyc1(1'b1, 1'b1, 1'b1, 1'b1);
        cyc1(1'b1, 1'b1, 1'b1, 1'b0);
        cyc1(1'b0, 1'b1, 1'b1, 1'b0);
        cyc1(1'b0, 1'b1, 1'b1, 1'b0);
`else
        cyc1(1'b1, 1'b1, 1'b1, 1'b1);
        cyc1(1'b1, 1'b1, 1'b0, 1'b1);
        cyc1(1'b0, 1'b1, 1'b0, 1'b0);
        cyc1(1'b0, 1'b1, 1'b0, 1'b0);
`endif

        // Multi-bit bank.
        cyc4(4'b0011, 1'b1, 4'b0110, 4'b0011);
        cyc4(4'b0000, 1'b0, 4'b0110, 4'b0000);
        cyc4(4'b1111, 1'b1, 4'b1001, 4'b1111);
        cyc4(4'b0000, 1'b0, 4'b1001, 4'b0000);

        // Bring q1 to 1 while toggling, then pulse reset between edges.
`ifndef T_LATCH_ONESHOT_EN
        cyc1(1'b1, 1'b1, 1'b1, 1'b1);
`endif
        #2;
        t1  = 1'b1;
        en1 = 1'b1;
        rst = 1'b1;
        #1;
        chk("async_q1", {3'b000, q1}, 4'b0000);
        chk("async_q_bar1", {3'b000, qb1}, 4'b0001);
        chk("async_toggled1", {3'b000, tg1}, 4'b0000);
        chk("async_q4", q4, 4'b0101);
        #1;
        rst = 1'b0;
        cyc1(1'b1, 1'b1, 1'b0, 1'b0);
        cyc1(1'b1, 1'b1, 1'b1, 1'b1);
        cyc1(1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized t/enable/rst against a reference model.
        random_phase();

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0 entries left", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
